uart_boot_loader: RTL

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/loader_pkg.sv | 28 ++
 rtl/loader_timeout.sv | 32 +++
 rtl/uart_boot_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared encodings for the UART boot loader: FSM states and protocol bytes.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CKSUM = 3'd4,
    ST_RESP  = 3'd5,
    ST_RUN   = 3'd6
  } state_t;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  // Only the frame-receiving states are subject to the inter-byte timeout.
  function automatic logic timeout_armed(input state_t s);
    logic armed;
    case (s)
      ST_LEN0, ST_LEN1, ST_DATA, ST_CKSUM: armed = 1'b1;
      default:                             armed = 1'b0;
    endcase
    return armed;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts idle cycles, expires after TIMEOUT_CYCLES of them.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Idle-cycle counter, saturating at the expiry value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_r != LAST) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // A clear in the expiry cycle (a byte arriving) cancels the expiry.
  assign expire = !clear && (count_r == LAST);

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length/data/checksum frame, writes the words to
// instruction memory, answers ACK/NAK and releases the core on success.
module uart_boot_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 1024,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [31:0] MAX_WORDS_C = 32'(MAX_WORDS);

  state_t      state_r;
  logic [7:0]  len_lo_r;
  logic [15:0] len_r;
  logic [15:0] idx_r;
  logic [1:0]  byte_cnt_r;
  logic [31:0] word_r;
  logic [7:0]  cksum_r;

  logic [15:0] len_s;
  logic        len_bad_s;
  logic [31:0] word_next_s;
  logic        tmo_clear_s;
  logic        tmo_expire_s;

  assign len_s       = {rx_data, len_lo_r};
  assign len_bad_s   = (len_s == 16'd0) || ({16'd0, len_s} > MAX_WORDS_C);
  assign word_next_s = {rx_data, word_r[31:8]};
  assign tmo_clear_s = rx_valid || !timeout_armed(state_r);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear_s),
    .expire (tmo_expire_s)
  );

  // Frame FSM with registered memory, response and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      len_lo_r   <= 8'd0;
      len_r      <= 16'd0;
      idx_r      <= 16'd0;
      byte_cnt_r <= 2'd0;
      word_r     <= 32'd0;
      cksum_r    <= 8'd0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      load_error <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_valid && (rx_data == SYNC)) begin
            cksum_r <= 8'd0;
            state_r <= ST_LEN0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LEN0: begin
          if (rx_valid) begin
            len_lo_r <= rx_data;
            cksum_r  <= cksum_r ^ rx_data;
            state_r  <= ST_LEN1;
          end else begin
            state_r  <= ST_LEN0;
          end
        end
        ST_LEN1: begin
          if (rx_valid) begin
            len_r      <= len_s;
            idx_r      <= 16'd0;
            byte_cnt_r <= 2'd0;
            cksum_r    <= cksum_r ^ rx_data;
            if (len_bad_s) begin
              load_error <= 1'b1;
              tx_valid   <= 1'b1;
              tx_data    <= NAK;
              state_r    <= ST_RESP;
            end else begin
              state_r    <= ST_DATA;
            end
          end else begin
            state_r <= ST_LEN1;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            word_r     <= word_next_s;
            cksum_r    <= cksum_r ^ rx_data;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= word_next_s;
              imem_addr  <= BASE_ADDR + {14'd0, idx_r, 2'b00};
              idx_r      <= idx_r + 16'd1;
              if (idx_r == (len_r - 16'd1)) begin
                state_r <= ST_CKSUM;
              end else begin
                state_r <= ST_DATA;
              end
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_CKSUM: begin
          if (rx_valid) begin
            tx_valid <= 1'b1;
            state_r  <= ST_RESP;
            if (rx_data == cksum_r) begin
              tx_data <= ACK;
            end else begin
              tx_data    <= NAK;
              load_error <= 1'b1;
            end
          end else begin
            state_r <= ST_CKSUM;
          end
        end
        ST_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (tx_data == ACK) begin
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
              state_r   <= ST_RUN;
            end else begin
              state_r   <= ST_IDLE;
            end
          end else begin
            state_r <= ST_RESP;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      // Expiry only fires in a receiving state with no byte present, so it
      // never collides with a transition taken above.
      if (tmo_expire_s) begin
        load_error <= 1'b1;
        tx_valid   <= 1'b1;
        tx_data    <= NAK;
        state_r    <= ST_RESP;
      end
    end
  end

endmodule
